// File: rtl/vx_tcu_drl_pack_f8_if.sv
// Stream interface for the FP32 -> FP8/BF8 result packer.
//   in_*  : beat channel, N FP32 lanes per beat, lane 0 in the LSBs,
//           in_fmt selects the encoding, in_last closes a tile.
//   out_* : packed 32-bit word channel, earliest byte in [7:0],
//           out_last marks the word carrying the tile's final element.
// master drives beats and out_ready; slave is the packer.
interface vx_tcu_drl_pack_f8_if #(
    parameter int N = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [32*N-1:0] in_data;
    logic [2:0]      in_fmt;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic            out_last;

    modport master (
        output in_valid, in_data, in_fmt, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_fmt, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/vx_tcu_drl_pack_f8.sv
// Streaming FP32 -> OCP E4M3 (FP8) / E5M2 (BF8) encoder and byte packer.
//   clk, reset_n   : clock, synchronous active-low reset
//   bus (slave)    : beat input and packed-word output (see interface)
//   flag_overflow  : sticky, a value saturated / became Inf
//   flag_underflow : sticky, a tiny result lost precision
//   flag_inexact   : sticky, nonzero bits were discarded
// Pipeline: convert -> S1 register -> accumulate word -> output register.
// A beat that completes a word reaches out_valid two edges after acceptance.
// The interface N must match the module N.
module vx_tcu_drl_pack_f8 #(
    parameter int         N       = 2,
    parameter logic [2:0] BF8_FMT = 3'd2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vx_tcu_drl_pack_f8_if.slave  bus,
    output logic                 flag_overflow,
    output logic                 flag_underflow,
    output logic                 flag_inexact
);

    typedef struct packed {
        logic [7:0] b;
        logic       ovf;
        logic       unf;
        logic       inx;
    } cvt_t;

    localparam logic [1:0] CNT_STEP = 2'(N % 4);

    function automatic logic tcu_fmt_is_bfloat(input logic [2:0] fmt);
        return fmt == BF8_FMT;
    endfunction

    // Round-to-nearest-even conversion of one FP32 value.
    // The result code is built as ((te-1) << M) + (significand >> shift):
    // the hidden bit lands in the exponent field, so a mantissa carry or a
    // subnormal rounding up to the minimum normal falls out naturally.
    function automatic cvt_t cvt_fp8(input logic [31:0] x, input logic bf);
        cvt_t              r;
        logic              s;
        logic [7:0]        e;
        logic signed [9:0] te;
        logic [9:0]        extra;
        logic [9:0]        ts_full;
        logic [5:0]        ts;
        logic [55:0]       ext;
        logic [23:0]       base;
        logic [23:0]       code;
        logic              rnd;
        logic              sticky;
        logic              inc;
        s = x[31];
        e = x[30:23];
        r = '0;
        if (e == 8'hff) begin
            if (x[22:0] != 23'd0) begin
                r.b = {s, 7'h7f};
            end else if (bf) begin
                r.b = {s, 7'h7c};
            end else begin
                r.b   = {s, 7'h7e};
                r.ovf = 1'b1;
            end
        end else if (e == 8'd0) begin
            // FP32 subnormals are far below either target's minimum
            r.b   = {s, 7'h00};
            r.unf = (x[22:0] != 23'd0);
            r.inx = (x[22:0] != 23'd0);
        end else begin
            te      = $signed({2'b00, e}) - 10'sd127 + (bf ? 10'sd15 : 10'sd7);
            extra   = (te < 10'sd1) ? $unsigned(10'sd1 - te) : 10'd0;
            ts_full = (bf ? 10'd21 : 10'd20) + extra;
            // beyond 26 every bit is sticky; clamping keeps the shifter small
            ts      = (ts_full > 10'd26) ? 6'd26 : ts_full[5:0];
            ext     = {1'b1, x[22:0], 32'd0} >> ts;
            rnd     = ext[31];
            sticky  = |ext[30:0];
            inc     = rnd & (sticky | ext[32]);
            base    = (te < 10'sd1) ? 24'd0
                                    : (24'($unsigned(te - 10'sd1)) << (bf ? 2 : 3));
            code    = base + ext[55:32] + {23'd0, inc};
            r.inx   = rnd | sticky;
            r.unf   = (te < 10'sd1) && (rnd | sticky);
            if (code > (bf ? 24'd123 : 24'd126)) begin
                r.b   = {s, bf ? 7'h7c : 7'h7e};
                r.ovf = 1'b1;
                r.inx = 1'b1;
            end else begin
                r.b = {s, code[6:0]};
            end
        end
        return r;
    endfunction

    logic           is_bf;
    cvt_t           lane_cvt [N];
    logic [8*N-1:0] cvt_bytes;
    logic           cvt_ovf;
    logic           cvt_unf;
    logic           cvt_inx;

    assign is_bf = tcu_fmt_is_bfloat(bus.in_fmt);

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane_cvt[i] = cvt_fp8(bus.in_data[32*i +: 32], is_bf);
    end

    always_comb begin
        cvt_bytes = '0;
        cvt_ovf   = 1'b0;
        cvt_unf   = 1'b0;
        cvt_inx   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cvt_bytes[8*i +: 8] = lane_cvt[i].b;
            cvt_ovf = cvt_ovf | lane_cvt[i].ovf;
            cvt_unf = cvt_unf | lane_cvt[i].unf;
            cvt_inx = cvt_inx | lane_cvt[i].inx;
        end
    end

    logic           s1_valid;
    logic [8*N-1:0] s1_bytes;
    logic           s1_last;
    logic           s1_ovf;
    logic           s1_unf;
    logic           s1_inx;

    logic [31:0]    acc_word;
    logic [1:0]     cnt;
    logic           acc_full;
    logic           acc_last;

    logic           o_adv;
    logic           s1_adv;
    logic [1:0]     cnt_next;
    logic [31:0]    merged;
    logic           word_done;

    // A completed word waits in acc until the output register frees up;
    // S1 may enter acc on the same edge that word moves out.
    always_comb begin
        o_adv     = acc_full && (!bus.out_valid || bus.out_ready);
        s1_adv    = s1_valid && (!acc_full || o_adv);
        cnt_next  = cnt + CNT_STEP;
        merged    = (acc_full ? 32'd0 : acc_word) | (32'(s1_bytes) << {cnt, 3'b000});
        word_done = (cnt_next == 2'd0) || s1_last;
    end

    assign bus.in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid       <= 1'b0;
            s1_bytes       <= '0;
            s1_last        <= 1'b0;
            s1_ovf         <= 1'b0;
            s1_unf         <= 1'b0;
            s1_inx         <= 1'b0;
            acc_word       <= 32'd0;
            cnt            <= 2'd0;
            acc_full       <= 1'b0;
            acc_last       <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= 32'd0;
            bus.out_last   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                s1_valid <= 1'b1;
                s1_bytes <= cvt_bytes;
                s1_last  <= bus.in_last;
                s1_ovf   <= cvt_ovf;
                s1_unf   <= cvt_unf;
                s1_inx   <= cvt_inx;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                acc_word       <= merged;
                acc_full       <= word_done;
                acc_last       <= s1_last;
                cnt            <= word_done ? 2'd0 : cnt_next;
                flag_overflow  <= flag_overflow  | s1_ovf;
                flag_underflow <= flag_underflow | s1_unf;
                flag_inexact   <= flag_inexact   | s1_inx;
            end else if (o_adv) begin
                acc_word <= 32'd0;
                acc_full <= 1'b0;
            end

            if (o_adv) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= acc_word;
                bus.out_last  <= acc_last;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
